// File: rtl/lambdagen_pkg.sv
// lambdagen_pkg: cull-mode encodings and derived-width helpers shared by the
// triangle setup stages (s2, lambdagen_s3p, rasteriser).
package lambdagen_pkg;

  // Cull-mode encodings carried on the cull_mode bus
  localparam logic [1:0] CULL_NONE  = 2'd0;
  localparam logic [1:0] CULL_BACK  = 2'd1;
  localparam logic [1:0] CULL_FRONT = 2'd2;
  localparam logic [1:0] CULL_TWO   = 2'd3;

  // Width of one edge partial product (x-term or y-term)
  function automatic int pw(input int xw, input int yw);
    return xw + yw + 2;
  endfunction

  // Width of one area partial
  function automatic int aw(input int xw, input int yw);
    return pw(xw, yw) + 1;
  endfunction

endpackage

// File: rtl/lambdagen_skid.sv
// lambdagen_skid: two-entry skid buffer (output register OR + skid register SK)
// with a registered upstream ready, so the ready path never sees downstream
// combinational logic.
module lambdagen_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
);

  logic             r_or_valid;
  logic [WIDTH-1:0] r_or_data;
  logic             r_sk_valid;
  logic [WIDTH-1:0] r_sk_data;

  logic w_push;
  logic w_or_fire;

  // A push is only honoured while SK is free, so SK can never be overwritten.
  assign w_push    = i_valid & ~r_sk_valid;
  assign w_or_fire = r_or_valid & i_ready;

  assign o_ready = ~r_sk_valid;
  assign o_valid = r_or_valid;
  assign o_data  = r_or_data;

  // OR/SK occupancy and data movement; oldest beat always sits in OR
  always_ff @(posedge clk) begin
    if (rst) begin
      r_or_valid <= 1'b0;
      r_or_data  <= '0;
      r_sk_valid <= 1'b0;
      r_sk_data  <= '0;
    end else if (w_or_fire) begin
      if (r_sk_valid) begin
        // SK refills OR; SK empties (no push can coincide, ready was low)
        r_or_data  <= r_sk_data;
        r_sk_valid <= 1'b0;
      end else if (w_push) begin
        // fire and push in the same cycle: straight into OR, no bubble
        r_or_data <= i_data;
      end else begin
        r_or_valid <= 1'b0;
      end
    end else if (!r_or_valid) begin
      if (w_push) begin
        r_or_valid <= 1'b1;
        r_or_data  <= i_data;
      end
    end else if (w_push) begin
      // OR is held by backpressure: park the new beat in SK
      r_sk_valid <= 1'b1;
      r_sk_data  <= i_data;
    end
  end

endmodule

// File: rtl/lambdagen_s3p.sv
// lambdagen_s3p: sums the s2 edge/area partial products, applies culling and
// two-sided orientation normalisation, and forwards surviving triangles with
// their payload through a two-entry skid buffer. Keeps saturating
// accepted/culled statistics.
module lambdagen_s3p
  import lambdagen_pkg::*;
#(
  parameter  int XWIDTH = 9,
  parameter  int YWIDTH = 8,
  parameter  int NEDGE  = 3,
  parameter  int PAYW   = 64,
  parameter  int LWIDTH = 32,
  parameter  int CNTW   = 16,
  localparam int PW     = pw(XWIDTH, YWIDTH),
  localparam int AW     = aw(XWIDTH, YWIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NEDGE*PW-1:0]     exy_in,
  input  logic [NEDGE*PW-1:0]     eyx_in,
  input  logic [AW-1:0]           a0_in,
  input  logic [AW-1:0]           a1_in,
  input  logic [PAYW-1:0]         pay_in,
  input  logic [1:0]              cull_mode,
  input  logic                    cnt_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NEDGE*LWIDTH-1:0] e_out,
  output logic [LWIDTH-1:0]       area_out,
  output logic                    flip_out,
  output logic [PAYW-1:0]         pay_out,
  output logic [CNTW-1:0]         tri_cnt,
  output logic [CNTW-1:0]         cull_cnt
);

  localparam int SKW = 1 + LWIDTH + NEDGE * LWIDTH + PAYW;

  // The sums below rely on LWIDTH holding a full PW+1 / AW+1 result without wrap.
  if (LWIDTH < XWIDTH + YWIDTH + 5) begin : g_width_check
    $error("lambdagen_s3p: LWIDTH must be at least XWIDTH+YWIDTH+5");
  end

  logic                    w_accept;
  logic                    w_cull;
  logic                    w_flip;
  logic                    w_push;
  logic                    w_a_neg;
  logic                    w_a_zero;
  logic [LWIDTH-1:0]       w_a0_ext;
  logic [LWIDTH-1:0]       w_a1_ext;
  logic [LWIDTH-1:0]       w_area_raw;
  logic [LWIDTH-1:0]       w_area;
  logic [NEDGE*LWIDTH-1:0] w_edge;
  logic [SKW-1:0]          w_push_word;
  logic [SKW-1:0]          w_out_word;
  logic                    w_skid_ready;

  logic [CNTW-1:0] r_tri_cnt;
  logic [CNTW-1:0] r_cull_cnt;

  assign in_ready = w_skid_ready;
  assign w_accept = in_valid & w_skid_ready;

  // Area: both partials sign-extended to LWIDTH before the add
  assign w_a0_ext   = {{(LWIDTH-AW){a0_in[AW-1]}}, a0_in};
  assign w_a1_ext   = {{(LWIDTH-AW){a1_in[AW-1]}}, a1_in};
  assign w_area_raw = w_a0_ext + w_a1_ext;
  assign w_a_neg    = w_area_raw[LWIDTH-1];
  assign w_a_zero   = (w_area_raw == '0);

  // Cull decision from the area sign, per the cull mode sampled on accept
  always_comb begin
    w_cull = 1'b0;
    case (cull_mode)
      CULL_NONE:  w_cull = 1'b0;
      CULL_BACK:  w_cull = w_a_neg | w_a_zero;
      CULL_FRONT: w_cull = ~w_a_neg;
      CULL_TWO:   w_cull = w_a_zero;
      default:    w_cull = 1'b0;
    endcase
  end

  // Two-sided mode renormalises clockwise triangles to positive area
  assign w_flip = (cull_mode == CULL_TWO) & w_a_neg;
  assign w_area = w_flip ? (~w_area_raw + 1'b1) : w_area_raw;

  for (genvar gi = 0; gi < NEDGE; gi++) begin : g_edge
    logic [LWIDTH-1:0] w_x_ext;
    logic [LWIDTH-1:0] w_y_ext;
    logic [LWIDTH-1:0] w_sum;
    assign w_x_ext = {{(LWIDTH-PW){exy_in[gi*PW+PW-1]}}, exy_in[gi*PW +: PW]};
    assign w_y_ext = {{(LWIDTH-PW){eyx_in[gi*PW+PW-1]}}, eyx_in[gi*PW +: PW]};
    assign w_sum   = w_x_ext + w_y_ext;
    assign w_edge[gi*LWIDTH +: LWIDTH] = w_flip ? (~w_sum + 1'b1) : w_sum;
  end

  assign w_push      = w_accept & ~w_cull;
  assign w_push_word = {w_flip, w_area, w_edge, pay_in};

  lambdagen_skid #(
    .WIDTH (SKW)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_push),
    .i_data  (w_push_word),
    .o_ready (w_skid_ready),
    .o_valid (out_valid),
    .o_data  (w_out_word),
    .i_ready (out_ready)
  );

  assign {flip_out, area_out, e_out, pay_out} = w_out_word;

  // Saturating statistics; a clear overrides any same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_tri_cnt  <= '0;
      r_cull_cnt <= '0;
    end else if (w_accept) begin
      if (r_tri_cnt != '1) begin
        r_tri_cnt <= r_tri_cnt + CNTW'(1);
      end
      if (w_cull && (r_cull_cnt != '1)) begin
        r_cull_cnt <= r_cull_cnt + CNTW'(1);
      end
    end
  end

  assign tri_cnt  = r_tri_cnt;
  assign cull_cnt = r_cull_cnt;

endmodule

// File: tb/tb_lambdagen_s3p.sv
// tb_lambdagen_s3p: directed vector table, hand-written skid/reset/counter
// sequences and a randomized run, all compared against a queue-based model of
// the stage (depth-2 in-order buffer, arithmetic done on plain integers).
module tb_lambdagen_s3p;

  localparam int PW = 19;
  localparam int AW = 20;
  localparam int LW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  wire           in_ready;
  logic [3*PW-1:0] exy_in;
  logic [3*PW-1:0] eyx_in;
  logic [AW-1:0] a0_in;
  logic [AW-1:0] a1_in;
  logic [63:0]   pay_in;
  logic [1:0]    cull_mode;
  logic          cnt_clr;
  wire           out_valid;
  logic          out_ready;
  wire [3*LW-1:0] e_out;
  wire [LW-1:0]  area_out;
  wire           flip_out;
  wire [63:0]    pay_out;
  wire [15:0]    tri_cnt;
  wire [15:0]    cull_cnt;

  wire           in_ready4;
  wire           out_valid4;
  wire [3*LW-1:0] e_out4;
  wire [LW-1:0]  area_out4;
  wire           flip_out4;
  wire [63:0]    pay_out4;
  wire [3:0]     tri_cnt4;
  wire [3:0]     cull_cnt4;

  lambdagen_s3p dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .exy_in(exy_in), .eyx_in(eyx_in), .a0_in(a0_in), .a1_in(a1_in),
    .pay_in(pay_in), .cull_mode(cull_mode), .cnt_clr(cnt_clr),
    .out_valid(out_valid), .out_ready(out_ready), .e_out(e_out),
    .area_out(area_out), .flip_out(flip_out), .pay_out(pay_out),
    .tri_cnt(tri_cnt), .cull_cnt(cull_cnt)
  );

  lambdagen_s3p #(.CNTW(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .exy_in(exy_in), .eyx_in(eyx_in), .a0_in(a0_in), .a1_in(a1_in),
    .pay_in(pay_in), .cull_mode(cull_mode), .cnt_clr(cnt_clr),
    .out_valid(out_valid4), .out_ready(out_ready), .e_out(e_out4),
    .area_out(area_out4), .flip_out(flip_out4), .pay_out(pay_out4),
    .tri_cnt(tri_cnt4), .cull_cnt(cull_cnt4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] e0, e1, e2, area;
    logic        flip;
    logic [63:0] pay;
  } out_t;

  typedef struct {
    logic [1:0] mode;
    int x0, x1, x2, y0, y1, y2, a0, a1;
    bit ev;
    int e0, e1, e2, ar;
    bit fl;
  } vec_t;

  out_t q[$];
  int   m_tri, m_cull;
  int   cur_x[3], cur_y[3], cur_a0, cur_a1;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl[11];

  function automatic logic [63:0] z32(input logic [31:0] v);
    return {32'b0, v};
  endfunction

  function automatic vec_t mkv(input logic [1:0] m, input int x0, x1, x2, y0, y1, y2,
                               input int a0, a1, input bit ev, input int e0, e1, e2, ar,
                               input bit fl);
    vec_t v;
    v.mode = m; v.x0 = x0; v.x1 = x1; v.x2 = x2; v.y0 = y0; v.y1 = y1; v.y2 = y2;
    v.a0 = a0; v.a1 = a1; v.ev = ev; v.e0 = e0; v.e1 = e1; v.e2 = e2; v.ar = ar; v.fl = fl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_beat(input bit v, input logic [1:0] m, input int x0, x1, x2,
                          input int y0, y1, y2, input int a0, a1, input logic [63:0] p);
    in_valid  = v;
    cull_mode = m;
    cur_x[0] = x0; cur_x[1] = x1; cur_x[2] = x2;
    cur_y[0] = y0; cur_y[1] = y1; cur_y[2] = y2;
    cur_a0 = a0;   cur_a1 = a1;
    for (int i = 0; i < 3; i++) begin
      exy_in[i*PW +: PW] = PW'(cur_x[i]);
      eyx_in[i*PW +: PW] = PW'(cur_y[i]);
    end
    a0_in  = AW'(a0);
    a1_in  = AW'(a1);
    pay_in = p;
  endtask

  function automatic logic [63:0] sat(input int n, input int mx);
    return 64'((n > mx) ? mx : n);
  endfunction

  // Compare both DUTs against the model state after an edge
  task automatic check_state();
    out_t h;
    chk("out_valid",   64'(out_valid),  64'(q.size() > 0));
    chk("in_ready",    64'(in_ready),   64'(q.size() < 2));
    chk("out_valid4",  64'(out_valid4), 64'(q.size() > 0));
    chk("in_ready4",   64'(in_ready4),  64'(q.size() < 2));
    chk("tri_cnt",     64'(tri_cnt),    sat(m_tri, 65535));
    chk("cull_cnt",    64'(cull_cnt),   sat(m_cull, 65535));
    chk("tri_cnt4",    64'(tri_cnt4),   sat(m_tri, 15));
    chk("cull_cnt4",   64'(cull_cnt4),  sat(m_cull, 15));
    if (q.size() > 0) begin
      h = q[0];
      chk("e0",    z32(e_out[0*LW +: LW]), z32(h.e0));
      chk("e1",    z32(e_out[1*LW +: LW]), z32(h.e1));
      chk("e2",    z32(e_out[2*LW +: LW]), z32(h.e2));
      chk("area",  z32(area_out), z32(h.area));
      chk("flip",  64'(flip_out), 64'(h.flip));
      chk("pay",   pay_out, h.pay);
      chk("e_4",   {32'b0, e_out4[0 +: LW] ^ e_out4[LW +: LW] ^ e_out4[2*LW +: LW]},
                   z32(h.e0 ^ h.e1 ^ h.e2));
      chk("area4", z32(area_out4), z32(h.area));
      chk("flip4", 64'(flip_out4), 64'(h.flip));
      chk("pay4",  pay_out4, h.pay);
    end
  endtask

  // One clock: model decides from the driven inputs, then both are compared
  task automatic step();
    longint s[3];
    longint a;
    bit     cull, flip, acc, fire;
    out_t   b;
    acc  = in_valid && (q.size() < 2);
    fire = (q.size() > 0) && out_ready;
    a    = longint'(cur_a0) + longint'(cur_a1);
    if (cull_mode == 2'd0)      cull = 1'b0;
    else if (cull_mode == 2'd1) cull = (a <= 0);
    else if (cull_mode == 2'd2) cull = (a >= 0);
    else                        cull = (a == 0);
    flip = (cull_mode == 2'd3) && (a < 0);
    for (int i = 0; i < 3; i++) begin
      s[i] = longint'(cur_x[i]) + longint'(cur_y[i]);
      if (flip) s[i] = -s[i];
    end
    if (flip) a = -a;
    b.e0 = s[0][31:0]; b.e1 = s[1][31:0]; b.e2 = s[2][31:0];
    b.area = a[31:0]; b.flip = flip; b.pay = pay_in;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      m_tri  = 0;
      m_cull = 0;
    end else begin
      if (acc) $display("accept t=%0t mode=%0d A=%0d culled=%0d pay=%0h",
                        $time, cull_mode, longint'(cur_a0) + longint'(cur_a1), cull, pay_in);
      if (fire) void'(q.pop_front());
      if (acc && !cull) q.push_back(b);
      if (cnt_clr) begin
        m_tri  = 0;
        m_cull = 0;
      end else if (acc) begin
        m_tri++;
        if (cull) m_cull++;
      end
    end
    check_state();
  endtask

  task automatic idle();
    set_beat(1'b0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0);
  endtask

  initial begin
    vec_t v;
    m_tri = 0; m_cull = 0;
    rst = 1'b1; cnt_clr = 1'b0; out_ready = 1'b1;
    idle();
    step();
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_e_out",     e_out[63:0] | {32'b0, e_out[95:64]}, 64'd0);
    chk("rst_area",      z32(area_out), 64'd0);
    chk("rst_pay",       pay_out, 64'd0);
    chk("rst_tri_cnt",   64'(tri_cnt), 64'd0);
    rst = 1'b0;

    // Directed vector table, out_ready held high
    tbl[0]  = mkv(2'd0, 10, 20, 30, 1, 2, 3, 5, -2, 1, 11, 22, 33, 3, 0);
    tbl[1]  = mkv(2'd3, 4, 0, 0, 1, 0, 0, -7, 0, 1, -5, 0, 0, 7, 1);
    tbl[2]  = mkv(2'd3, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mkv(2'd1, 1, 2, 3, 0, 0, 0, 4, 0, 1, 1, 2, 3, 4, 0);
    tbl[4]  = mkv(2'd1, 4, 5, 6, 0, 0, 0, -4, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mkv(2'd1, 5, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mkv(2'd1, 7, 8, 9, 0, 0, 0, 1, 0, 1, 7, 8, 9, 1, 0);
    tbl[7]  = mkv(2'd3, -262144, 0, 0, -262144, 0, 0, -1, 0, 1, 524288, 0, 0, 1, 1);
    tbl[8]  = mkv(2'd2, 1, 1, 1, 1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mkv(2'd2, 100, -200, 300, -1, -1, -1, -3, 0, 1, 99, -201, 299, -3, 0);
    tbl[10] = mkv(2'd0, 0, 0, 0, -5, 5, 0, 6, -6, 1, -5, 5, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      v = tbl[i];
      set_beat(1'b1, v.mode, v.x0, v.x1, v.x2, v.y0, v.y1, v.y2, v.a0, v.a1,
               64'hA000 + 64'(i));
      step();
      $display("vector %0d mode=%0d expect_out=%0d", i, v.mode, v.ev);
      chk("vec_valid", 64'(out_valid), 64'(v.ev));
      if (v.ev) begin
        chk("vec_e0",   z32(e_out[0 +: LW]),  z32(v.e0));
        chk("vec_e1",   z32(e_out[LW +: LW]), z32(v.e1));
        chk("vec_e2",   z32(e_out[2*LW +: LW]), z32(v.e2));
        chk("vec_area", z32(area_out), z32(v.ar));
        chk("vec_flip", 64'(flip_out), 64'(v.fl));
        chk("vec_pay",  pay_out, 64'hA000 + 64'(i));
      end
      if (i == 0) chk("vec_tri_cnt1", 64'(tri_cnt), 64'd1);
      if (i == 2) chk("vec_cull_cnt1", 64'(cull_cnt), 64'd1);
      if (i == 6) chk("vec_cull_cnt3", 64'(cull_cnt), 64'd3);
    end
    idle();
    step();

    // Backpressure: fill OR and SK, then drain in order
    out_ready = 1'b0;
    set_beat(1'b1, 2'd0, 1, 1, 1, 1, 1, 1, 1, 1, 64'hB1);
    step();
    chk("bp_ready1", 64'(in_ready), 64'd1);
    set_beat(1'b1, 2'd0, 2, 2, 2, 2, 2, 2, 2, 2, 64'hB2);
    step();
    chk("bp_ready2", 64'(in_ready), 64'd0);
    set_beat(1'b1, 2'd0, 3, 3, 3, 3, 3, 3, 3, 3, 64'hB3);
    step();
    chk("bp_ready3", 64'(in_ready), 64'd0);
    chk("bp_hold",   pay_out, 64'hB1);
    out_ready = 1'b1;
    step();
    chk("bp_drain1", pay_out, 64'hB2);
    chk("bp_ready4", 64'(in_ready), 64'd1);
    step();
    chk("bp_nobubble", pay_out, 64'hB3);
    idle();
    step();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Reset with OR and SK both full
    out_ready = 1'b0;
    set_beat(1'b1, 2'd0, 1, 2, 3, 4, 5, 6, 7, 8, 64'hC1);
    step();
    set_beat(1'b1, 2'd3, 1, 2, 3, 4, 5, 6, -7, -8, 64'hC2);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_cnt",   64'(tri_cnt) | 64'(cull_cnt), 64'd0);
    chk("mid_rst_data",  pay_out | z32(area_out) | 64'(flip_out), 64'd0);
    out_ready = 1'b1;

    // cnt_clr coincident with a culled accept
    set_beat(1'b1, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 64'hD1);
    step();
    step();
    set_beat(1'b1, 2'd1, 0, 0, 0, 0, 0, 0, -1, 0, 64'hD2);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_tri",  64'(tri_cnt),  64'd0);
    chk("clr_cull", 64'(cull_cnt), 64'd0);

    // 20 accepts: the 4-bit counter sticks at 15
    for (int i = 0; i < 20; i++) begin
      set_beat(1'b1, 2'd0, i, 0, 0, 0, 0, 0, 1, 0, 64'hE00 + 64'(i));
      step();
    end
    chk("sat_tri4", 64'(tri_cnt4), 64'd15);
    chk("sat_tri",  64'(tri_cnt),  64'd20);
    idle();
    step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int x[3], y[3], a0, a1;
      for (int k = 0; k < 3; k++) begin
        x[k] = int'($urandom_range(0, 524287)) - 262144;
        y[k] = int'($urandom_range(0, 524287)) - 262144;
      end
      a0 = int'($urandom_range(0, 524287)) - 262144;
      a1 = ($urandom_range(0, 5) == 0) ? -a0 : int'($urandom_range(0, 1048575)) - 524288;
      set_beat($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), x[0], x[1], x[2],
               y[0], y[1], y[2], a0, a1, {$urandom, $urandom});
      out_ready = ($urandom_range(0, 9) < 6);
      cnt_clr   = ($urandom_range(0, 40) == 0);
      rst       = ($urandom_range(0, 120) == 0);
      step();
    end
    rst = 1'b0; cnt_clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
